// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcode/funct constants, the
// ALU operation enum driven into ID/EX, the control bundle, and the
// funct3-to-ALU mapping used by both R-type and I-type ALU decode.
package id_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
  } ctrl_t;

  // alt selects SUB/SRA (funct7 = 0100000 form)
  function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline register bundle.
//   master: driven by id_stage (registered operands, indices, controls)
//   slave : consumed by the execute stage
interface id_stage_if
  import id_pkg::*;
#(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] id_ex_pc_4;
  logic [XLEN-1:0] id_ex_rs1_val;
  logic [XLEN-1:0] id_ex_rs2_val;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0]      id_ex_rs1;
  logic [4:0]      id_ex_rs2;
  logic [4:0]      id_ex_rd;
  alu_op_t         id_ex_alu_op;
  logic            id_ex_alu_src;
  logic            id_ex_mem_read;
  logic            id_ex_mem_write;
  logic            id_ex_reg_write;
  logic            id_ex_mem_to_reg;

  modport master (
    output id_ex_pc_4, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alu_src,
           id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg
  );

  modport slave (
    input  id_ex_pc_4, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_alu_op, id_ex_alu_src,
           id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg
  );
endinterface

// File: rtl/id_stage_regfile.sv
// 2-read / 1-write register file.
//   clk, rst : clock, synchronous active-high clear of all registers
//   ra1, ra2 : async read addresses -> rd1, rd2
//   we, wa, wd : synchronous write port (writes to x0 dropped)
// Reads of x0 return 0; a read of the address being written this cycle
// returns wd (write-through bypass).
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = mem[ra1];
    if (ra1 == '0)             rd1 = '0;
    else if (wr_en && wa == ra1) rd1 = wd;
  end

  always_comb begin
    rd2 = mem[ra2];
    if (ra2 == '0)             rd2 = '0;
    else if (wr_en && wa == ra2) rd2 = wd;
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
//   clk, rst              : clock, synchronous active-high reset
//   if_id_pc_4/instr      : IF/ID register contents
//   wb_we/wb_rd/wb_data   : writeback port into the register file
//   ex_*/mem_*            : hazard info from the EX and MEM stages
//   stall                 : hold PC and IF/ID this cycle
//   branch_taken/target   : combinational BEQ/BNE redirect to fetch
//   id_ex                 : registered ID/EX pipeline bundle
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_id_pc_4,
  input  logic [31:0]     if_id_instr,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic [4:0]      ex_rd,
  input  logic            mem_mem_read,
  input  logic [4:0]      mem_rd,
  output logic            stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target,
  id_stage_if.master      id_ex
);

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [4:0]      rd_f, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode = if_id_instr[6:0];
  assign rd_f   = if_id_instr[11:7];
  assign f3     = if_id_instr[14:12];
  assign rs1    = if_id_instr[19:15];
  assign rs2    = if_id_instr[24:20];
  assign f7     = if_id_instr[31:25];

  assign imm_i = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:20]};
  assign imm_s = {{(XLEN-12){if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
  assign imm_b = {{(XLEN-13){if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                  if_id_instr[30:25], if_id_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){if_id_instr[31]}}, if_id_instr[31:12], 12'b0};

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (wb_we),
    .wa  (wb_rd),
    .wd  (wb_data)
  );

  ctrl_t           ctrl;
  logic [4:0]      rd_dec;
  logic [XLEN-1:0] imm;
  logic            rs1_used, rs2_used, is_branch, is_bne, alt, shift;

  // Unsupported opcodes and illegal funct encodings decode as a bubble.
  always_comb begin
    ctrl      = '0;
    rd_dec    = '0;
    imm       = '0;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    is_branch = 1'b0;
    is_bne    = 1'b0;
    alt       = (f7 == F7_ALT);
    shift     = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
    case (opcode)
      OP_R: begin
        if (f7 == F7_BASE || (alt && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))) begin
          ctrl.alu_op    = f3_to_alu(f3, alt);
          ctrl.reg_write = 1'b1;
          rd_dec         = rd_f;
          rs1_used       = 1'b1;
          rs2_used       = 1'b1;
        end
      end
      OP_I: begin
        // funct7 only qualifies the shift-immediates; elsewhere it is imm bits
        if (!shift || f7 == F7_BASE || (alt && f3 == F3_SRL_SRA)) begin
          ctrl.alu_op    = f3_to_alu(f3, shift && alt);
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          rd_dec         = rd_f;
          imm            = imm_i;
          rs1_used       = 1'b1;
        end
      end
      OP_LOAD: begin
        if (f3 == F3_LW) begin
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          rd_dec          = rd_f;
          imm             = imm_i;
          rs1_used        = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 == F3_SW) begin
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          imm            = imm_s;
          rs1_used       = 1'b1;
          rs2_used       = 1'b1;
        end
      end
      OP_BRANCH: begin
        // resolved here; travels down the pipe as a bubble
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          is_branch = 1'b1;
          is_bne    = (f3 == F3_BNE);
          imm       = imm_b;
          rs1_used  = 1'b1;
          rs2_used  = 1'b1;
        end
      end
      OP_LUI: begin
        ctrl.alu_op    = ALU_PASSB;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        rd_dec         = rd_f;
        imm            = imm_u;
      end
      default: ;
    endcase
  end

  function automatic logic src_hit(input logic [4:0] r, input logic [4:0] a1, a2,
                                   input logic u1, u2);
    return (r != '0) && ((u1 && a1 == r) || (u2 && a2 == r));
  endfunction

  logic hit_ex, hit_mem;
  assign hit_ex  = src_hit(ex_rd,  rs1, rs2, rs1_used, rs2_used);
  assign hit_mem = src_hit(mem_rd, rs1, rs2, rs1_used, rs2_used);

  // Branches compare in ID with no forwarding, so they also wait on any
  // pending EX write and on a load still in MEM.
  assign stall = (ex_mem_read && hit_ex) ||
                 (is_branch && ((ex_reg_write && hit_ex) || (mem_mem_read && hit_mem)));

  assign branch_target = if_id_pc_4 - XLEN'(4) + imm_b;
  assign branch_taken  = is_branch && !stall &&
                         (is_bne ? (rs1_val != rs2_val) : (rs1_val == rs2_val));

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex.id_ex_pc_4       <= '0;
      id_ex.id_ex_rs1_val    <= '0;
      id_ex.id_ex_rs2_val    <= '0;
      id_ex.id_ex_imm        <= '0;
      id_ex.id_ex_rs1        <= '0;
      id_ex.id_ex_rs2        <= '0;
      id_ex.id_ex_rd         <= '0;
      id_ex.id_ex_alu_op     <= ALU_ADD;
      id_ex.id_ex_alu_src    <= 1'b0;
      id_ex.id_ex_mem_read   <= 1'b0;
      id_ex.id_ex_mem_write  <= 1'b0;
      id_ex.id_ex_reg_write  <= 1'b0;
      id_ex.id_ex_mem_to_reg <= 1'b0;
    end else begin
      id_ex.id_ex_pc_4       <= if_id_pc_4;
      id_ex.id_ex_rs1_val    <= rs1_val;
      id_ex.id_ex_rs2_val    <= rs2_val;
      id_ex.id_ex_imm        <= imm;
      id_ex.id_ex_rs1        <= rs1;
      id_ex.id_ex_rs2        <= rs2;
      id_ex.id_ex_rd         <= stall ? '0 : rd_dec;
      id_ex.id_ex_alu_op     <= stall ? ALU_ADD : ctrl.alu_op;
      id_ex.id_ex_alu_src    <= !stall && ctrl.alu_src;
      id_ex.id_ex_mem_read   <= !stall && ctrl.mem_read;
      id_ex.id_ex_mem_write  <= !stall && ctrl.mem_write;
      id_ex.id_ex_reg_write  <= !stall && ctrl.reg_write;
      id_ex.id_ex_mem_to_reg <= !stall && ctrl.mem_to_reg;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage of the 5-stage RV32I pipeline. It consumes the IF/ID register (pc_4, instr) and contains the 32x32 register file. It resolves BEQ/BNE in ID and returns branch_target/branch_taken to the fetch stage. It detects load-use and branch-operand hazards, and drives the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width
NREGS, 32, register-file depth (x0 hardwired zero)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_id_pc_4  in  32  PC+4 of instruction in ID
if_id_instr  in  32  instruction in ID
wb_we  in  1  writeback enable
wb_rd  in  5  writeback destination
wb_data  in  32  writeback value
ex_mem_read  in  1  instruction in EX is a load
ex_reg_write  in  1  instruction in EX writes rd
ex_rd  in  5  rd of instruction in EX
mem_mem_read  in  1  instruction in MEM is a load
mem_rd  in  5  rd of instruction in MEM
stall  out  1  hold PC and IF/ID this cycle
branch_taken  out  1  redirect fetch (combinational)
branch_target  out  32  redirect address (combinational)
id_ex_pc_4, id_ex_rs1_val, id_ex_rs2_val, id_ex_imm  out  32 each  registered operands
id_ex_rs1, id_ex_rs2, id_ex_rd  out  5 each  registered register indices
id_ex_alu_op  out  4  registered ALU op (package enum)
id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg  out  1 each  registered controls

Behaviour:
- Reset:
  - All id_ex_* outputs = 0.
  - Register file cleared to 0.
  - The combinational outputs (stall, branch_taken, branch_target) follow the IF/ID inputs, which are zero under reset, giving stall=0 and branch_taken=0.
- Supported decode: R-type (ADD SUB AND OR XOR SLL SRL SRA SLT SLTU), I-ALU (ADDI ANDI ORI XORI SLTI SLTIU SLLI SRLI SRAI), LW, SW, BEQ, BNE, LUI.
- Any other opcode, including instr=0: all control bits 0 (bubble); id_ex_rd=0.
- Immediates are sign-extended per format: I, S, B (bit 0 = 0), U (imm[31:12], low 12 bits 0).
- Register file:
  - Two async read ports, one sync write port on posedge when wb_we && wb_rd!=0.
  - Writes to x0 are ignored; reads of x0 return 0.
  - Write-through bypass: a read of wb_rd while wb_we=1 returns wb_data in the same cycle.
- Used sources:
  - rs1 is used by all supported types except LUI.
  - rs2 is used by R, SW, BEQ, BNE.
  - Hazard comparisons apply only to used, non-zero sources.
- stall=1 when either condition holds:
  - (a) Load-use: ex_mem_read && ex_rd matches a used source.
  - (b) Current instr is BEQ/BNE and either:
    - ex_reg_write && ex_rd matches a used source, or
    - mem_mem_read && mem_rd matches a used source.
  - There is no EX->ID forwarding.
- Branch:
  - branch_target = if_id_pc_4 - 4 + imm_B, modulo 2^32 (wrap allowed).
  - branch_taken = is_branch && !stall && (BEQ ? rs1_val==rs2_val : rs1_val!=rs2_val).
  - Flushing IF/ID on branch_taken is the fetch side's job. ID/EX captures the branch as a bubble (no reg_write, no mem).
- ID/EX register, on every posedge when rst=0:
  - If stall: all control bits <= 0 and id_ex_rd <= 0; data fields are don't-care and are loaded normally.
  - Else: capture the decoded fields.
  - Latency from IF/ID to ID/EX is 1 cycle.
- Simultaneous WB write and ID read of the same register: the bypass value is used, both for operands and for the branch compare.
- Reset mid-stall: reset wins; id_ex_* = 0 on the next edge.

Decomposition:
- Package id_pkg holds:
  - opcode constants (OP_R=0110011, OP_I=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011, OP_LUI=0110111);
  - funct3/funct7 constants;
  - the 4-bit alu_op enum: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9 PASSB=10.
- Sub-module regfile (2R1W, x0 zero, write-through bypass), instantiated once.

Test Plan:
- Reset then instr=0 -> all id_ex_* = 0, stall=0, branch_taken=0.
- wb_we=1, wb_rd=5, wb_data=0x1234 in the same cycle as ADDI x6,x5,-1 -> next cycle id_ex_rs1_val=0x1234, id_ex_imm=0xFFFFFFFF, alu_op=ADD, alu_src=1, reg_write=1, id_ex_rd=6.
- ex_mem_read=1, ex_rd=7 with ADD x8,x7,x1 in ID -> stall=1, next ID/EX controls all 0; with ex_rd=0 -> stall=0.
- x1=x2=42, BEQ x1,x2,-8 at if_id_pc_4=0x104 -> branch_taken=1, branch_target=0xF8; BNE with the same inputs -> branch_taken=0.
- BEQ x3,x4 with ex_reg_write=1, ex_rd=4 -> stall=1, branch_taken=0; after ex_reg_write=0 -> resolves normally.
- Write x0 with wb_data=0xDEAD, then SW x0,4(x0) -> id_ex_rs2_val=0, mem_write=1, imm=4; LUI x9,0xABCDE -> imm=0xABCDE000, alu_op=PASSB.
